mips_trace_checker: RTL and testbench
=====================================

# mips_trace_checker

Parametrised commit-trace and run-control monitor that sits beside `mips_processor` and snoops its register-file write port, data-memory write port and PC. It captures every architectural write into a FIFO for a bench or debug host to drain, counts cycles and drops, and detects program end (PC self-loop) or runaway (timeout). It is the hardware successor to the ad-hoc `$monitor` and final-register dumps: traces are cycle-exact, bounded, and available while the core runs.

## Interface
- `DATA_W`, 32: width of write data and PC.
- `ADDR_W`, 32: width of memory write address.
- `DEPTH`, 16: trace FIFO entries; power of two, at least 2.
- `HALT_CYCLES`, 4: consecutive cycles of unchanged PC that declare halt; at least 1.
- `MAX_CYCLES`, 1024: RUN-cycle budget before timeout.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `en` in 1: level run enable.
- `pc` in DATA_W: core `pc_current`.
- `reg_write` in 1: core register write enable.
- `reg_write_addr` in 5: destination register.
- `reg_write_data` in DATA_W: register write data.
- `mem_write` in 1: core memory write enable.
- `mem_write_addr` in ADDR_W: memory byte address.
- `mem_write_data` in DATA_W: memory write data.
- `trace_valid` out 1: FIFO head is valid.
- `trace_ready` in 1: consumer accepts head.
- `trace_kind` out 1: 0 = register write, 1 = memory write.
- `trace_addr` out ADDR_W: register number (zero-extended) or memory address.
- `trace_data` out DATA_W: written data.
- `state` out 2: 0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT.
- `done` out 1: state is HALTED or TIMEOUT.
- `cycle_count` out 32: RUN cycles elapsed.
- `drop_count` out 16: events lost to a full FIFO, saturating at 0xFFFF.
- `overflow` out 1: sticky, set on the first drop.
- `overlap_err` out 1: sticky, set when `reg_write` and `mem_write` occur in the same RUN cycle.

## Operation
- State machine:
  - IDLE to RUN when `en` = 1.
  - RUN to IDLE when `en` = 0; counters and FIFO hold.
  - RUN to HALTED on halt detection.
  - RUN to TIMEOUT on timeout.
  - HALTED and TIMEOUT are left only by `reset`.
- Event capture happens in RUN only.
  - A register event is `reg_write` = 1 with `reg_write_addr` != 0. Writes to R0 are never traced.
  - A memory event is `mem_write` = 1.
  - If both occur in one cycle, the register event is pushed, the memory event is dropped (counted in `drop_count`), and `overlap_err` is set.
- FIFO:
  - Push on an event; pop on `trace_valid && trace_ready`.
  - When full, a push is accepted only if a pop occurs in the same cycle. Otherwise the event is dropped, `drop_count` increments (saturating) and `overflow` sets.
  - A pop when empty does nothing.
  - Pointers wrap modulo DEPTH. Occupancy is held as a DEPTH+1-state count, so full and empty are unambiguous.
  - Draining continues in every state.
- Halt detection:
  - A previous-PC register and a valid flag are loaded every RUN cycle. The flag clears in IDLE.
  - The stable counter increments when the flag is set and `pc` equals the previous PC. Otherwise it is 0.
  - HALTED is entered on the edge where the counter reaches HALT_CYCLES.
- Timeout: `cycle_count` increments each RUN cycle. TIMEOUT is entered on the edge where it becomes MAX_CYCLES.
- Halt beats timeout when both are detected on the same edge.

## Timing
- Reset values:
  - `state` = IDLE.
  - `done`, `trace_valid`, `overflow`, `overlap_err` = 0.
  - `cycle_count`, `drop_count` = 0.
  - `trace_kind`, `trace_addr`, `trace_data` = 0.
  - FIFO is empty; PC history is invalid.
- `en` rising: state reads RUN one cycle later. Inputs are sampled from that first RUN cycle onward.
- Push latency: an event sampled at edge N gives `trace_valid` = 1 after edge N when the FIFO was empty. Output is registered, with no combinational path from snoop inputs.
- Head data is stable while `trace_valid && !trace_ready`.
- One push and one pop per cycle are sustained at full throughput.
- Events in the cycle that triggers HALTED or TIMEOUT are still captured. Nothing is captured afterwards.
- `done` asserts in the same cycle `state` changes.
- `cycle_count` freezes in HALTED, TIMEOUT and IDLE.
- `reset` mid-run discards the FIFO contents and all counters on that edge.

## Test plan
- **Basic program.** Run the core program that writes R8=5, R9=7, R10=0xC and Mem[0]=0xC, with `trace_ready` = 1.
  - Trace order: (0,8,5), (0,9,7), (0,10,0xC), then (1,0,0xC).
  - `drop_count` = 0.
- **Halt detection.** With HALT_CYCLES=4, the PC sits at 0x34 for 4 consecutive cycles after changing.
  - HALTED and `done` = 1 on the 4th equal-PC edge.
  - `cycle_count` freezes at that point.
- **Overflow.** With DEPTH=4 and `trace_ready` = 0, inject 6 register writes.
  - 4 entries are held; `drop_count` = 2; `overflow` = 1.
  - Draining returns the first 4 events in order.
- **Full plus simultaneous pop.** FIFO full, with push and pop in the same cycle.
  - The push is accepted and occupancy stays 4.
  - `drop_count` is unchanged.
- **Filtering and overlap.**
  - A write to R0 with data 0xFFFF is not traced.
  - Same-cycle register and memory writes set `overlap_err` and increment `drop_count`.
- **Timeout and reset.** With MAX_CYCLES=8 and the PC incrementing, TIMEOUT is entered after 8 RUN cycles.
  - Asserting `reset` returns IDLE with every output at its reset value.

Source files
------------

// File: rtl/mips_trace_checker.sv
// Commit-trace and run-control monitor for mips_processor.
// Snoops register-file and data-memory write ports plus the PC, buffers every
// architectural write in a trace FIFO, and flags program end (PC self-loop)
// or runaway (cycle budget exhausted).
module mips_trace_checker #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] pc,
  input  logic              reg_write,
  input  logic [4:0]        reg_write_addr,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_write_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic              trace_kind,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic [1:0]        state,
  output logic              done,
  output logic [31:0]       cycle_count,
  output logic [15:0]       drop_count,
  output logic              overflow,
  output logic              overlap_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam int EW = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] prev_pc_q, prev_pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic [SW-1:0]     stable_q, stable_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              halt_hit, timeout_hit;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       drop_q, drop_d;
  logic              overflow_q, overflow_d;
  logic              overlap_q, overlap_d;
  logic [EW-1:0]     fifo_mem [DEPTH];

  logic              run, reg_ev, mem_ev, push_req, push_ok, pop, full;
  logic              full_drop, ovl;
  logic [EW-1:0]     push_entry, head_entry;
  logic [16:0]       drop_sum;

  // Run-control FSM: PC-stability halt detector and RUN-cycle budget.
  always_comb begin
    state_d     = state_q;
    prev_pc_d   = prev_pc_q;
    pc_valid_d  = pc_valid_q;
    stable_d    = stable_q;
    cycle_d     = cycle_q;
    halt_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pc_valid_d = 1'b0;
        stable_d   = '0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        prev_pc_d  = pc;
        pc_valid_d = 1'b1;
        if (pc_valid_q && (pc == prev_pc_q)) stable_d = stable_q + SW'(1);
        else                                 stable_d = '0;
        cycle_d     = cycle_q + 32'd1;
        halt_hit    = (stable_d == SW'(HALT_CYCLES));
        timeout_hit = (cycle_d == 32'(MAX_CYCLES));
        // Halt wins over timeout when both land on the same edge.
        if (halt_hit)         state_d = ST_HALTED;
        else if (timeout_hit) state_d = ST_TIMEOUT;
        else if (!en)         state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  // Event capture, FIFO pointer/occupancy update and drop bookkeeping.
  always_comb begin
    run      = (state_q == ST_RUN);
    reg_ev   = run && reg_write && (reg_write_addr != 5'd0);
    mem_ev   = run && mem_write;
    push_req = reg_ev || mem_ev;
    ovl      = reg_ev && mem_ev;
    pop      = (count_q != '0) && trace_ready;
    full     = (count_q == CW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok   = push_req && (!full || pop);
    full_drop = push_req && !push_ok;

    if (reg_ev) push_entry = {1'b0, ADDR_W'(reg_write_addr), reg_write_data};
    else        push_entry = {1'b1, mem_write_addr, mem_write_data};

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    drop_sum   = {1'b0, drop_q} + 17'(ovl) + 17'(full_drop);
    drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q | full_drop;
    overlap_d  = overlap_q | ovl;
  end

  // State and counter registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_pc_q  <= '0;
      pc_valid_q <= 1'b0;
      stable_q   <= '0;
      cycle_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      overlap_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_pc_q  <= prev_pc_d;
      pc_valid_q <= pc_valid_d;
      stable_q   <= stable_d;
      cycle_q    <= cycle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      overlap_q  <= overlap_d;
    end
  end

  // Trace storage; no reset so it maps onto RAM, validity lives in count_q.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_entry;
  end

  // Head is masked to zero while the FIFO is empty so outputs read 0 after reset.
  always_comb begin
    head_entry  = fifo_mem[rd_ptr_q];
    trace_valid = (count_q != '0);
    trace_kind  = trace_valid ? head_entry[EW-1] : 1'b0;
    trace_addr  = trace_valid ? head_entry[EW-2 -: ADDR_W] : '0;
    trace_data  = trace_valid ? head_entry[DATA_W-1:0] : '0;
    state       = state_q;
    done        = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
    cycle_count = cycle_q;
    drop_count  = drop_q;
    overflow    = overflow_q;
    overlap_err = overlap_q;
  end

endmodule

// File: tb/tb_mips_trace_checker.sv
// Self-checking bench for mips_trace_checker: table-driven cycle vectors with a
// trace scoreboard filled as events are driven and drained by a monitor.
module tb_mips_trace_checker;

  logic        clk = 1'b0;
  logic        reset, en, reg_write, mem_write, trace_ready;
  logic [31:0] pc, reg_write_data, mem_write_addr, mem_write_data;
  logic [4:0]  reg_write_addr;
  logic        trace_valid, trace_kind, done, overflow, overlap_err;
  logic [31:0] trace_addr, trace_data, cycle_count;
  logic [1:0]  state;
  logic [15:0] drop_count;

  mips_trace_checker #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(4), .HALT_CYCLES(4), .MAX_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pc(pc),
    .reg_write(reg_write), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_kind(trace_kind),
    .trace_addr(trace_addr), .trace_data(trace_data), .state(state), .done(done),
    .cycle_count(cycle_count), .drop_count(drop_count), .overflow(overflow),
    .overlap_err(overlap_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        en, rdy, rw;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        mw;
    logic [31:0] ma, md;
    logic        keep;
    logic [1:0]  st;
    logic        dn;
    logic [31:0] cyc;
  } vec_t;

  typedef struct packed {
    logic        kind;
    logic [31:0] addr;
    logic [31:0] data;
  } tr_t;

  vec_t tbl[$];
  tr_t  sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(logic [31:0] pc_i, logic en_i, logic rdy_i, logic rw_i,
                              logic [4:0] ra_i, logic [31:0] rd_i, logic mw_i,
                              logic [31:0] ma_i, logic [31:0] md_i, logic keep_i,
                              logic [1:0] st_i, logic dn_i, logic [31:0] cyc_i);
    vec_t v;
    v.pc = pc_i; v.en = en_i; v.rdy = rdy_i; v.rw = rw_i; v.ra = ra_i; v.rd = rd_i;
    v.mw = mw_i; v.ma = ma_i; v.md = md_i; v.keep = keep_i; v.st = st_i; v.dn = dn_i;
    v.cyc = cyc_i;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic clear_inputs();
    pc = '0; reg_write = 0; reg_write_addr = '0; reg_write_data = '0;
    mem_write = 0; mem_write_addr = '0; mem_write_data = '0;
  endtask

  task automatic do_reset();
    reset = 1; en = 0; trace_ready = 0;
    clear_inputs();
    step();
    step();
    sb.delete();
    reset = 0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, " state"}, 32'(state), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " trace_valid"}, 32'(trace_valid), 32'd0);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
    chk({tag, " overlap_err"}, 32'(overlap_err), 32'd0);
    chk({tag, " cycle_count"}, cycle_count, 32'd0);
    chk({tag, " drop_count"}, 32'(drop_count), 32'd0);
    chk({tag, " trace_kind"}, 32'(trace_kind), 32'd0);
    chk({tag, " trace_addr"}, trace_addr, 32'd0);
    chk({tag, " trace_data"}, trace_data, 32'd0);
  endtask

  task automatic start_run(string tag);
    en = 1;
    step();
    chk({tag, " enter RUN"}, 32'(state), 32'd1);
  endtask

  // Drive each table row for one cycle; kept events go into the scoreboard.
  task automatic run_table(string tag);
    tr_t t;
    foreach (tbl[i]) begin
      pc = tbl[i].pc; en = tbl[i].en; trace_ready = tbl[i].rdy;
      reg_write = tbl[i].rw; reg_write_addr = tbl[i].ra; reg_write_data = tbl[i].rd;
      mem_write = tbl[i].mw; mem_write_addr = tbl[i].ma; mem_write_data = tbl[i].md;
      if (tbl[i].keep) begin
        if (tbl[i].rw && tbl[i].ra != 5'd0) t = '{kind: 1'b0, addr: 32'(tbl[i].ra), data: tbl[i].rd};
        else                                t = '{kind: 1'b1, addr: tbl[i].ma, data: tbl[i].md};
        sb.push_back(t);
      end
      step();
      $display("%s row %0d: pc=%h state=%0d done=%0d cycles=%0d drops=%0d",
               tag, i, tbl[i].pc, state, done, cycle_count, drop_count);
      chk($sformatf("%s[%0d] state", tag, i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("%s[%0d] done", tag, i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("%s[%0d] cycle_count", tag, i), cycle_count, tbl[i].cyc);
    end
    tbl.delete();
    clear_inputs();
  endtask

  task automatic drain(string tag);
    trace_ready = 1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    chk({tag, " scoreboard empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && trace_valid && trace_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL trace_unexpected: got kind=%0d addr=%h data=%h, expected no entry",
                 trace_kind, trace_addr, trace_data);
      end else begin
        tr_t e;
        e = sb.pop_front();
        $display("trace pop: kind=%0d addr=%h data=%h", trace_kind, trace_addr, trace_data);
        if (trace_kind === e.kind && trace_addr === e.addr && trace_data === e.data) n_pass++;
        else $display("FAIL trace_entry: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                      trace_kind, trace_addr, trace_data, e.kind, e.addr, e.data);
      end
    end
  end

  initial begin
    do_reset();
    check_reset_outputs("reset");

    // Basic program: R8=5, R9=7, R10=0xC, Mem[0]=0xC.
    start_run("basic");
    tbl.push_back(mk(32'h00, 1, 1, 1, 5'd8,  32'h5, 0, 0, 0, 1, 2'd1, 0, 1));
    tbl.push_back(mk(32'h04, 1, 1, 1, 5'd9,  32'h7, 0, 0, 0, 1, 2'd1, 0, 2));
    tbl.push_back(mk(32'h08, 1, 1, 1, 5'd10, 32'hC, 0, 0, 0, 1, 2'd1, 0, 3));
    tbl.push_back(mk(32'h0C, 1, 1, 0, 5'd0,  32'h0, 1, 32'h0, 32'hC, 1, 2'd1, 0, 4));
    tbl.push_back(mk(32'h10, 1, 1, 0, 5'd0,  32'h0, 0, 0, 0, 0, 2'd1, 0, 5));
    tbl.push_back(mk(32'h14, 0, 1, 0, 5'd0,  32'h0, 0, 0, 0, 0, 2'd0, 0, 6));
    tbl.push_back(mk(32'h18, 0, 1, 0, 5'd0,  32'h0, 0, 0, 0, 0, 2'd0, 0, 6));
    run_table("basic");
    drain("basic");
    chk("basic drop_count", 32'(drop_count), 32'd0);

    // Halt: PC settles at 0x34; HALTED on the 4th equal-PC edge.
    do_reset();
    start_run("halt");
    tbl.push_back(mk(32'h30, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd1, 0, 1));
    tbl.push_back(mk(32'h34, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd1, 0, 2));
    tbl.push_back(mk(32'h34, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd1, 0, 3));
    tbl.push_back(mk(32'h34, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd1, 0, 4));
    tbl.push_back(mk(32'h34, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd1, 0, 5));
    tbl.push_back(mk(32'h34, 1, 1, 1, 5'd3, 32'h33, 0, 0, 0, 1, 2'd2, 1, 6));
    tbl.push_back(mk(32'h34, 1, 1, 1, 5'd4, 32'h44, 0, 0, 0, 0, 2'd2, 1, 6));
    tbl.push_back(mk(32'h38, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd2, 1, 6));
    run_table("halt");
    drain("halt");

    // Overflow: 6 writes into 4 entries, then a push that coincides with a pop.
    do_reset();
    start_run("ovf");
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(32'h100 + 32'(4 * i), 1, 0, 1, 5'(i + 1), 32'h100 + 32'(i),
                       0, 0, 0, (i < 4), 2'd1, 0, 32'(i + 1)));
    tbl.push_back(mk(32'h118, 0, 1, 1, 5'd7, 32'h107, 0, 0, 0, 1, 2'd0, 0, 7));
    run_table("ovf");
    trace_ready = 0;
    step();
    chk("ovf drop_count", 32'(drop_count), 32'd2);
    chk("ovf overflow", 32'(overflow), 32'd1);
    chk("ovf trace_valid held", 32'(trace_valid), 32'd1);
    trace_ready = 1;
    repeat (4) step();
    chk("ovf empty after 4 pops", 32'(trace_valid), 32'd0);
    chk("ovf scoreboard empty", 32'(sb.size()), 32'd0);
    chk("ovf drop_count after drain", 32'(drop_count), 32'd2);

    // Filtering and overlap: R0 ignored, reg+mem in one cycle drops the mem write.
    do_reset();
    start_run("ovl");
    tbl.push_back(mk(32'h40, 1, 1, 1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 2'd1, 0, 1));
    tbl.push_back(mk(32'h44, 1, 1, 1, 5'd5, 32'h55, 1, 32'h80, 32'h99, 1, 2'd1, 0, 2));
    tbl.push_back(mk(32'h48, 1, 1, 0, 5'd0, 0, 1, 32'h84, 32'hAB, 1, 2'd1, 0, 3));
    tbl.push_back(mk(32'h4C, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd0, 0, 4));
    run_table("ovl");
    drain("ovl");
    chk("ovl overlap_err", 32'(overlap_err), 32'd1);
    chk("ovl drop_count", 32'(drop_count), 32'd1);

    // Halt and timeout on the same edge: halt wins.
    do_reset();
    start_run("hbt");
    tbl.push_back(mk(32'h00, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd1, 0, 1));
    tbl.push_back(mk(32'h04, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd1, 0, 2));
    tbl.push_back(mk(32'h08, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd1, 0, 3));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(32'h10, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd1, 0, 32'(4 + i)));
    tbl.push_back(mk(32'h10, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0, 2'd2, 1, 8));
    run_table("hbt");

    // Timeout after 8 RUN cycles; event on the timeout edge is kept, later ones are not.
    do_reset();
    start_run("tmo");
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(32'h200 + 32'(4 * i), 1, 0, 0, 5'd0, 0, 0, 0, 0, 0, 2'd1, 0, 32'(i + 1)));
    tbl.push_back(mk(32'h21C, 1, 0, 1, 5'd2, 32'h22, 0, 0, 0, 1, 2'd3, 1, 8));
    tbl.push_back(mk(32'h220, 1, 0, 1, 5'd6, 32'h66, 0, 0, 0, 0, 2'd3, 1, 8));
    run_table("tmo");
    chk("tmo trace_valid", 32'(trace_valid), 32'd1);
    chk("tmo head data", trace_data, 32'h22);
    do_reset();
    check_reset_outputs("tmo reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
